// File: rtl/ecb_stream_ctrl.sv
// Message sequencer around the bitwise ECB XOR datapath. The key phase is
// carried across words so the keystream runs bit-continuously over a message.

module ecb_xor_datapath #(
    parameter int BLOCK_SIZE = 8,
    parameter int SYNC_SIZE  = 4
) (
    input  logic [BLOCK_SIZE-1:0] key,
    input  logic [SYNC_SIZE-1:0]  data,
    output logic [SYNC_SIZE-1:0]  result
);

    // Bit i is XORed with key bit i mod BLOCK_SIZE; the key arrives pre-rotated.
    always_comb begin
        result = {SYNC_SIZE{1'b0}};
        for (int i = 0; i < SYNC_SIZE; i++) begin
            result[i] = data[i] ^ key[i % BLOCK_SIZE];
        end
    end

endmodule

module ecb_stream_ctrl #(
    parameter int BLOCK_SIZE = 8,
    parameter int SYNC_SIZE  = 4,
    parameter int MAX_WORDS  = 16,
    localparam int LW = $clog2(MAX_WORDS + 1),
    localparam int PW = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [BLOCK_SIZE-1:0] key_in,
    input  logic                  key_load,
    input  logic [LW-1:0]         len_in,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [SYNC_SIZE-1:0]  in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [SYNC_SIZE-1:0]  out_data,
    output logic                  busy,
    output logic                  key_valid,
    output logic                  done,
    output logic [PW-1:0]         key_phase
);

    localparam int            STEP    = SYNC_SIZE % BLOCK_SIZE;
    localparam logic [PW:0]   STEP_W  = (PW + 1)'(STEP);
    localparam logic [PW:0]   BS_W    = (PW + 1)'(BLOCK_SIZE);
    localparam logic [LW-1:0] MAX_LEN = LW'(MAX_WORDS);
    localparam logic [LW-1:0] ONE_W   = LW'(32'd1);
    localparam logic [LW-1:0] ZERO_W  = LW'(32'd0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READY = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t                state_r;
    logic [BLOCK_SIZE-1:0] key_r;
    logic [LW-1:0]         rem_in_r;
    logic [LW-1:0]         rem_out_r;
    logic [BLOCK_SIZE-1:0] rot_key_s;
    logic [SYNC_SIZE-1:0]  ct_s;
    logic [PW:0]           phase_sum_s;
    logic [PW:0]           phase_wrap_s;
    logic [PW-1:0]         phase_next_s;
    logic [LW-1:0]         len_clamp_s;
    logic                  in_fire_s;
    logic                  out_fire_s;

    assign in_ready   = (state_r == ST_RUN) && (rem_in_r != ZERO_W) && (!out_valid || out_ready);
    assign in_fire_s  = in_valid && in_ready;
    assign out_fire_s = out_valid && out_ready;

    // Doubling the key turns the rotation by the phase into a plain right shift.
    always_comb begin
        rot_key_s = BLOCK_SIZE'({key_r, key_r} >> key_phase);
    end

    // Phase advance: one add and at most one subtract, since both terms are below BLOCK_SIZE.
    always_comb begin
        phase_sum_s = {1'b0, key_phase} + STEP_W;
        if (phase_sum_s >= BS_W) begin
            phase_wrap_s = phase_sum_s - BS_W;
        end else begin
            phase_wrap_s = phase_sum_s;
        end
        phase_next_s = PW'(phase_wrap_s);
    end

    // Requested length saturates at the message capacity.
    always_comb begin
        if (len_in > MAX_LEN) begin
            len_clamp_s = MAX_LEN;
        end else begin
            len_clamp_s = len_in;
        end
    end

    ecb_xor_datapath #(
        .BLOCK_SIZE(BLOCK_SIZE),
        .SYNC_SIZE (SYNC_SIZE)
    ) u_datapath (
        .key   (rot_key_s),
        .data  (in_data),
        .result(ct_s)
    );

    // Control FSM with registered data, status and word counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            key_r     <= {BLOCK_SIZE{1'b0}};
            key_valid <= 1'b0;
            key_phase <= {PW{1'b0}};
            out_valid <= 1'b0;
            out_data  <= {SYNC_SIZE{1'b0}};
            busy      <= 1'b0;
            done      <= 1'b0;
            rem_in_r  <= ZERO_W;
            rem_out_r <= ZERO_W;
        end else begin
            done <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (key_load) begin
                        key_r     <= key_in;
                        key_valid <= 1'b1;
                        state_r   <= ST_READY;
                    end
                end
                ST_READY: begin
                    if (key_load) begin
                        key_r     <= key_in;
                        key_valid <= 1'b1;
                    end
                    if (start) begin
                        if (len_clamp_s == ZERO_W) begin
                            done <= 1'b1;
                        end else begin
                            state_r   <= ST_RUN;
                            busy      <= 1'b1;
                            rem_in_r  <= len_clamp_s;
                            rem_out_r <= len_clamp_s;
                            key_phase <= {PW{1'b0}};
                        end
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        state_r   <= ST_READY;
                        busy      <= 1'b0;
                        out_valid <= 1'b0;
                        key_phase <= {PW{1'b0}};
                        rem_in_r  <= ZERO_W;
                        rem_out_r <= ZERO_W;
                    end else begin
                        // A new word overrides the clear from a same-cycle output handshake.
                        if (in_fire_s) begin
                            out_data  <= ct_s;
                            out_valid <= 1'b1;
                            key_phase <= phase_next_s;
                            rem_in_r  <= rem_in_r - ONE_W;
                        end else if (out_fire_s) begin
                            out_valid <= 1'b0;
                        end
                        if (out_fire_s) begin
                            rem_out_r <= rem_out_r - ONE_W;
                            if (rem_out_r == ONE_W) begin
                                state_r <= ST_READY;
                                busy    <= 1'b0;
                                done    <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    busy      <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ecb_stream_ctrl.sv
// Scoreboard bench for ecb_stream_ctrl: an 8-bit-key instance for most scenarios
// and a 3-bit-key instance for the non-power-of-two phase wrap.

module tb_ecb_stream_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] key_in;
    logic       key_load, start, abort, in_valid, out_ready;
    logic [4:0] len_in;
    logic [3:0] in_data;
    logic       in_ready, out_valid, busy, key_valid, done;
    logic [3:0] out_data;
    logic [2:0] key_phase;

    logic [2:0] key_in3;
    logic       key_load3, start3, abort3, in_valid3, out_ready3;
    logic [4:0] len_in3;
    logic [3:0] in_data3;
    logic       in_ready3, out_valid3, busy3, key_valid3, done3;
    logic [3:0] out_data3;
    logic [1:0] key_phase3;

    int         compared = 0;
    int         mismatched = 0;
    logic [3:0] exp_q[$];
    logic [3:0] pt_arr[16];
    logic [3:0] got_arr[16];
    logic [7:0] cur_key;

    ecb_stream_ctrl #(.BLOCK_SIZE(8), .SYNC_SIZE(4), .MAX_WORDS(16)) u_dut8 (
        .clk(clk), .rst(rst), .key_in(key_in), .key_load(key_load), .len_in(len_in),
        .start(start), .abort(abort), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .busy(busy), .key_valid(key_valid), .done(done),
        .key_phase(key_phase)
    );

    ecb_stream_ctrl #(.BLOCK_SIZE(3), .SYNC_SIZE(4), .MAX_WORDS(16)) u_dut3 (
        .clk(clk), .rst(rst), .key_in(key_in3), .key_load(key_load3), .len_in(len_in3),
        .start(start3), .abort(abort3), .in_valid(in_valid3), .in_ready(in_ready3),
        .in_data(in_data3), .out_valid(out_valid3), .out_ready(out_ready3),
        .out_data(out_data3), .busy(busy3), .key_valid(key_valid3), .done(done3),
        .key_phase(key_phase3)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] model_ct(input logic [7:0] key, input int bs,
                                            input logic [3:0] pt, input int p);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = pt[i] ^ key[(p + i) % bs];
        return r;
    endfunction

    task automatic load_key(input logic [7:0] k);
        key_in = k; key_load = 1'b1; cur_key = k;
        @(negedge clk);
        key_load = 1'b0;
    endtask

    // Runs one message on the 8-bit instance; the scoreboard model tracks the phase.
    task automatic drive_message(input logic [4:0] len_field, input int nwords, input int stall_cycles,
                                 output int cycles, output int n_done);
        int p, sent, recvd, stall_left;
        bit stalled_once;
        logic [3:0] held, exp;
        p = 0; sent = 0; recvd = 0; stall_left = 0; stalled_once = 1'b0; held = 4'h0;
        n_done = 0; cycles = 0;
        exp_q.delete();
        len_in = len_field; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        compared++;
        if (busy !== 1'b1) begin mismatched++; $display("FAIL start_busy: got %b want 1", busy); end
        while (recvd < nwords && cycles < 200) begin
            if (stall_cycles > 0 && !stalled_once && out_valid === 1'b1) begin
                stall_left = stall_cycles; stalled_once = 1'b1; held = out_data;
            end
            out_ready = (stall_left == 0);
            in_valid  = (sent < nwords);
            in_data   = (sent < nwords) ? pt_arr[sent] : 4'h0;
            #1;
            compared++;
            if (key_phase !== 3'(p)) begin
                mismatched++; $display("FAIL phase: got %0d want %0d", key_phase, p);
            end
            if (stall_left > 0) begin
                compared++;
                if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== held) begin
                    mismatched++;
                    $display("FAIL stall_hold: in_ready=%b out_valid=%b data=%h want 0/1/%h",
                             in_ready, out_valid, out_data, held);
                end
                stall_left--;
            end
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                compared++;
                if (exp_q.size() == 0) begin
                    mismatched++; $display("FAIL unexpected_out: got %h with empty scoreboard", out_data);
                end else begin
                    exp = exp_q.pop_front();
                    if (out_data !== exp) begin
                        mismatched++; $display("FAIL out_data[%0d]: got %h want %h", recvd, out_data, exp);
                    end
                end
                if (recvd < 16) got_arr[recvd] = out_data;
                recvd++;
            end
            if (in_valid === 1'b1 && in_ready === 1'b1) begin
                exp_q.push_back(model_ct(cur_key, 8, in_data, p));
                p = (p + 4) % 8;
                sent++;
            end
            @(negedge clk);
            cycles++;
            if (done === 1'b1) n_done++;
        end
        in_valid = 1'b0; out_ready = 1'b0;
        compared++;
        if (recvd != nwords) begin mismatched++; $display("FAIL timeout: got %0d words want %0d", recvd, nwords); end
        compared++;
        if (busy !== 1'b0) begin mismatched++; $display("FAIL busy_end: got %b want 0", busy); end
        compared++;
        if (key_phase !== 3'(p)) begin mismatched++; $display("FAIL phase_end: got %0d want %0d", key_phase, p); end
        compared++;
        if (exp_q.size() != 0 || sent != nwords) begin
            mismatched++; $display("FAIL word_count: sent %0d left %0d want %0d/0", sent, exp_q.size(), nwords);
        end
        @(negedge clk);
        compared++;
        if (done !== 1'b0) begin mismatched++; $display("FAIL done_width: got %b want 0", done); end
    endtask

    task automatic test_reset();
        @(negedge clk);
        compared++;
        if ({in_ready, out_valid, out_data, busy, key_valid, done, key_phase} !== 12'h000) begin
            mismatched++;
            $display("FAIL reset8: got %h want 000", {in_ready, out_valid, out_data, busy, key_valid, done, key_phase});
        end
        compared++;
        if ({in_ready3, out_valid3, out_data3, busy3, key_valid3, done3, key_phase3} !== 11'h000) begin
            mismatched++;
            $display("FAIL reset3: got %h want 000", {in_ready3, out_valid3, out_data3, busy3, key_valid3, done3, key_phase3});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_idle_start();
        len_in = 5'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        compared++;
        if (busy !== 1'b0 || in_ready !== 1'b0 || key_valid !== 1'b0) begin
            mismatched++; $display("FAIL idle_start: busy=%b in_ready=%b key_valid=%b want 0/0/0", busy, in_ready, key_valid);
        end
        @(negedge clk);
        compared++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            mismatched++; $display("FAIL idle_done: done=%b busy=%b want 0/0", done, busy);
        end
    endtask

    task automatic test_basic();
        int cyc, nd;
        load_key(8'hA5);
        compared++;
        if (key_valid !== 1'b1) begin mismatched++; $display("FAIL key_valid: got %b want 1", key_valid); end
        pt_arr[0] = 4'hF; pt_arr[1] = 4'hF;
        drive_message(5'd2, 2, 0, cyc, nd);
        compared++;
        if (got_arr[0] !== 4'hA || got_arr[1] !== 4'h5) begin
            mismatched++; $display("FAIL basic_ct: got %h %h want a 5", got_arr[0], got_arr[1]);
        end
        compared++;
        if (nd != 1) begin mismatched++; $display("FAIL basic_done: got %0d pulses want 1", nd); end
    endtask

    task automatic test_block3();
        int p, sent, recvd;
        logic [3:0] exp;
        logic [3:0] got3[2];
        p = 0; sent = 0; recvd = 0; got3[0] = 4'h0; got3[1] = 4'h0;
        exp_q.delete();
        key_in3 = 3'b101; key_load3 = 1'b1;
        @(negedge clk);
        key_load3 = 1'b0; len_in3 = 5'd2; start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        for (int cyc = 0; cyc < 20 && recvd < 2; cyc++) begin
            in_valid3 = (sent < 2); in_data3 = 4'h0; out_ready3 = 1'b1;
            #1;
            compared++;
            if (key_phase3 !== 2'(p)) begin mismatched++; $display("FAIL phase3: got %0d want %0d", key_phase3, p); end
            if (out_valid3 === 1'b1) begin
                compared++;
                if (exp_q.size() == 0) begin
                    mismatched++; $display("FAIL unexpected_out3: got %h", out_data3);
                end else begin
                    exp = exp_q.pop_front();
                    if (out_data3 !== exp) begin mismatched++; $display("FAIL out3: got %h want %h", out_data3, exp); end
                end
                got3[recvd] = out_data3;
                recvd++;
            end
            if (in_valid3 === 1'b1 && in_ready3 === 1'b1) begin
                exp_q.push_back(model_ct(8'h05, 3, in_data3, p));
                p = (p + 4) % 3;
                sent++;
            end
            @(negedge clk);
        end
        in_valid3 = 1'b0; out_ready3 = 1'b0;
        compared++;
        if (recvd != 2 || got3[0] !== 4'hD || got3[1] !== 4'h6) begin
            mismatched++; $display("FAIL block3_ct: got %0d words %h %h want d 6", recvd, got3[0], got3[1]);
        end
        compared++;
        if (key_phase3 !== 2'd2 || busy3 !== 1'b0) begin
            mismatched++; $display("FAIL block3_end: phase=%0d busy=%b want 2/0", key_phase3, busy3);
        end
    endtask

    task automatic test_backpressure();
        int cyc, nd;
        for (int i = 0; i < 4; i++) pt_arr[i] = 4'($urandom_range(15));
        drive_message(5'd4, 4, 5, cyc, nd);
        compared++;
        if (nd != 1) begin mismatched++; $display("FAIL bp_done: got %0d pulses want 1", nd); end
    endtask

    task automatic test_len_zero();
        len_in = 5'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        compared++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            mismatched++; $display("FAIL len0_pulse: done=%b busy=%b want 1/0", done, busy);
        end
        @(negedge clk);
        compared++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            mismatched++; $display("FAIL len0_after: done=%b busy=%b want 0/0", done, busy);
        end
    endtask

    task automatic test_back_to_back();
        int cyc, nd;
        load_key(8'h3C);
        for (int i = 0; i < 16; i++) pt_arr[i] = 4'($urandom_range(15));
        drive_message(5'd31, 16, 0, cyc, nd);
        compared++;
        if (cyc != 17 || nd != 1) begin
            mismatched++; $display("FAIL b2b_clamp: got %0d cycles %0d done want 17/1", cyc, nd);
        end
    endtask

    task automatic test_abort();
        int cyc, nd;
        logic [3:0] first_ct, w0_exp;
        pt_arr[0] = 4'h9; pt_arr[1] = 4'h3;
        w0_exp = model_ct(cur_key, 8, 4'h9, 0);
        len_in = 5'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0; in_valid = 1'b1; in_data = pt_arr[0]; out_ready = 1'b1;
        @(negedge clk);
        first_ct = out_data;
        compared++;
        if (out_valid !== 1'b1 || first_ct !== w0_exp) begin
            mismatched++; $display("FAIL abort_w0: valid=%b data=%h want 1/%h", out_valid, first_ct, w0_exp);
        end
        in_data = pt_arr[1];
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0; abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        compared++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || key_phase !== 3'd0 || key_valid !== 1'b1) begin
            mismatched++;
            $display("FAIL abort_state: valid=%b busy=%b done=%b phase=%0d kv=%b want 0/0/0/0/1",
                     out_valid, busy, done, key_phase, key_valid);
        end
        @(negedge clk);
        compared++;
        if (done !== 1'b0) begin mismatched++; $display("FAIL abort_done: got %b want 0", done); end
        drive_message(5'd1, 1, 0, cyc, nd);
        compared++;
        if (got_arr[0] !== first_ct || nd != 1) begin
            mismatched++; $display("FAIL abort_restart: got %h done %0d want %h/1", got_arr[0], nd, first_ct);
        end
    endtask

    task automatic test_async_reset();
        len_in = 5'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0; in_valid = 1'b1; in_data = 4'h7; out_ready = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        compared++;
        if ({in_ready, out_valid, out_data, busy, key_valid, done, key_phase} !== 12'h000) begin
            mismatched++;
            $display("FAIL async_rst: got %h want 000", {in_ready, out_valid, out_data, busy, key_valid, done, key_phase});
        end
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        len_in = 5'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        compared++;
        if (busy !== 1'b0 || key_valid !== 1'b0 || in_ready !== 1'b0) begin
            mismatched++; $display("FAIL post_rst_start: busy=%b kv=%b in_ready=%b want 0/0/0", busy, key_valid, in_ready);
        end
    endtask

    initial begin
        rst = 1'b1;
        key_in = 8'h00; key_load = 1'b0; start = 1'b0; abort = 1'b0; len_in = 5'd0;
        in_valid = 1'b0; in_data = 4'h0; out_ready = 1'b0; cur_key = 8'h00;
        key_in3 = 3'b000; key_load3 = 1'b0; start3 = 1'b0; abort3 = 1'b0; len_in3 = 5'd0;
        in_valid3 = 1'b0; in_data3 = 4'h0; out_ready3 = 1'b0;
        for (int i = 0; i < 16; i++) begin pt_arr[i] = 4'h0; got_arr[i] = 4'h0; end
        test_reset();
        test_idle_start();
        test_basic();
        test_block3();
        test_backpressure();
        test_len_zero();
        test_back_to_back();
        test_abort();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
